sync_filter: RTL and testbench

//  Multi-channel clock-domain-crossing input conditioner for async single-bit signals (pins, flags, other-domain levels).
//  Per channel: STAGES-deep flop synchroniser, persistence (glitch) filter of FILT_CYCLES clocks, registered edge pulses,

---
 rtl/sync_filter_pkg.sv | 21 ++
 rtl/sync_filter_ch.sv | 67 ++++++
 rtl/sync_filter.sv | 37 +++
 tb/tb_sync_filter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_filter_pkg.sv
// Shared sizing helpers for the CDC input conditioners.
package sync_filter_pkg;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Persistence counter width; a one-cycle filter still keeps a 1-bit counter.
  function automatic int cnt_width(input int filt);
    return (clog2(filt) < 1) ? 1 : clog2(filt);
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: flop synchroniser, persistence filter, registered edge pulses, sticky event flag.
// Latency: STAGES+FILT_CYCLES-1 clocks from d_i sample to q_o.
// No backpressure; every clock samples the input.
module sync_filter_ch #(
  parameter int   STAGES      = 2,
  parameter int   FILT_CYCLES = 4,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  input  logic clr_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o,
  output logic evt_o
);
  import sync_filter_pkg::*;

  localparam int            CW      = cnt_width(FILT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_r;
  logic          s_sync;
  logic [CW-1:0] cnt;
  logic          fire;

  // Plain shift chain: nothing but flops between stages.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_r <= {STAGES{RST_VAL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d_i};
    end
  end

  assign s_sync = sync_r[STAGES-1];
  assign fire   = (s_sync != q_o) && (cnt == CNT_MAX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt    <= '0;
      q_o    <= RST_VAL;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      evt_o  <= 1'b0;
    end else begin
      rise_o <= fire && s_sync;
      fall_o <= fire && !s_sync;
      if (s_sync == q_o) begin
        cnt <= '0;
      end else if (fire) begin
        q_o <= s_sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      // An edge in the same cycle as a clear keeps the flag set.
      if (fire) begin
        evt_o <= 1'b1;
      end else if (clr_i) begin
        evt_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sync_filter.sv
// Multi-channel async input conditioner: one independent sync_filter_ch per bit.
// Latency: STAGES+FILT_CYCLES-1 clocks per channel; no cross-channel coherency.
// No backpressure; outputs update every clock.
module sync_filter #(
  parameter int   CHANNELS    = 4,
  parameter int   STAGES      = 2,
  parameter int   FILT_CYCLES = 4,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] d_i,
  input  logic [CHANNELS-1:0] clr_i,
  output logic [CHANNELS-1:0] q_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic [CHANNELS-1:0] evt_o
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    sync_filter_ch #(
      .STAGES      (STAGES),
      .FILT_CYCLES (FILT_CYCLES),
      .RST_VAL     (RST_VAL)
    ) u_ch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .d_i    (d_i[i]),
      .clr_i  (clr_i[i]),
      .q_o    (q_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i]),
      .evt_o  (evt_o[i])
    );
  end

endmodule

// File: tb/tb_sync_filter.sv
// Scoreboarded bench: reference model predicts each cycle's outputs from the input history.
module tb_sync_filter;
  localparam int   CH   = 4;
  localparam int   STG  = 2;
  localparam int   FILT = 4;
  localparam logic RST  = 1'b0;
  localparam int   STG2  = 3;
  localparam int   FILT2 = 1;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_i;
  logic [CH-1:0] d_i, clr_i, q_o, rise_o, fall_o, evt_o;
  logic          rst2;
  logic [CH-1:0] d2, clr2, q2, rise2, fall2, evt2;

  sync_filter #(.CHANNELS(CH), .STAGES(STG), .FILT_CYCLES(FILT), .RST_VAL(RST)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(d_i), .clr_i(clr_i),
    .q_o(q_o), .rise_o(rise_o), .fall_o(fall_o), .evt_o(evt_o)
  );

  sync_filter #(.CHANNELS(CH), .STAGES(STG2), .FILT_CYCLES(FILT2), .RST_VAL(RST)) dut2 (
    .clk_i(clk_i), .rst_i(rst2), .d_i(d2), .clr_i(clr2),
    .q_o(q2), .rise_o(rise2), .fall_o(fall2), .evt_o(evt2)
  );

  typedef struct packed {
    logic [CH-1:0] q;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] evt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: input samples per clock edge since reset release.
  logic          hist[CH][$];
  logic          mq[CH];
  logic          mevt[CH];
  int            n_edge;
  logic [CH-1:0] cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronised level seen by the filter at edge k: the input sampled STG edges earlier.
  function automatic logic ssync(input int ch, input int k);
    if (k - STG >= 1) return hist[ch][k-STG-1];
    return RST;
  endfunction

  task automatic model_reset(output exp_t e);
    n_edge = 0;
    for (int ch = 0; ch < CH; ch++) begin
      hist[ch].delete();
      mq[ch]   = RST;
      mevt[ch] = 1'b0;
    end
    e      = '0;
    e.q    = {CH{RST}};
  endtask

  // The output flips once the last FILT synchronised samples all differ from it.
  task automatic model_edge(input logic [CH-1:0] d, input logic [CH-1:0] clr, output exp_t e);
    logic flip;
    n_edge++;
    e = '0;
    for (int ch = 0; ch < CH; ch++) begin
      hist[ch].push_back(d[ch]);
      flip = (n_edge >= FILT);
      for (int j = 0; j < FILT; j++)
        if (n_edge - j >= 1 && ssync(ch, n_edge - j) == mq[ch]) flip = 1'b0;
      if (flip) begin
        mq[ch]     = ~mq[ch];
        e.rise[ch] = mq[ch];
        e.fall[ch] = ~mq[ch];
        mevt[ch]   = 1'b1;
      end else if (clr[ch]) begin
        mevt[ch] = 1'b0;
      end
      e.q[ch]   = mq[ch];
      e.evt[ch] = mevt[ch];
    end
  endtask

  task automatic step(input logic [CH-1:0] d, input logic [CH-1:0] clr, input logic rst);
    exp_t e;
    logic was;
    @(negedge clk_i);
    was   = rst_i;
    rst_i = rst;
    d_i   = d;
    clr_i = clr;
    if (rst) begin
      model_reset(e);
      if (!was) begin
        #1;
        check("async_rst_q", q_o, {CH{RST}});
        check("async_rst_fall", fall_o, 0);
        check("async_rst_evt", evt_o, 0);
      end
    end else begin
      model_edge(d, clr, e);
    end
    sb.push_back(e);
  endtask

  task automatic hold(input int n);
    repeat (n) step(cur, '0, 1'b0);
  endtask

  always @(posedge clk_i) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("q", q_o, e.q);
      check("rise", rise_o, e.rise);
      check("fall", fall_o, e.fall);
      check("evt", evt_o, e.evt);
    end
  end

  initial begin
    exp_t e0;
    int   lat;
    logic got;
    rst_i = 1'b1;
    d_i   = 4'hF;
    clr_i = '0;
    rst2  = 1'b1;
    d2    = '0;
    clr2  = '0;
    model_reset(e0);
    sb.push_back(e0);
    repeat (4) step(4'hF, '0, 1'b1);

    // Release with all inputs high: q_o rises five edges after the first sampling edge.
    cur = 4'hF;
    hold(8);
    cur = 4'h0;
    hold(8);

    // Clean step on ch0, then clear its event flag.
    cur[0] = 1'b1;
    hold(8);
    step(cur, 4'h1, 1'b0);
    hold(2);

    // Short glitch train on ch1.
    cur[1] = 1'b1; step(cur, '0, 1'b0);
    cur[1] = 1'b0; step(cur, '0, 1'b0);
    cur[1] = 1'b1; step(cur, '0, 1'b0);
    cur[1] = 1'b0; hold(8);

    // Bounce on ch2: the one-cycle low restarts the count.
    cur[2] = 1'b1; hold(3);
    cur[2] = 1'b0; hold(1);
    cur[2] = 1'b1; hold(10);

    // Clear coinciding with fall on ch3, then a clear on the next cycle.
    cur[3] = 1'b1; hold(8);
    cur[3] = 1'b0;
    step(cur, '0, 1'b0);
    hold(4);
    step(cur, 4'h8, 1'b0);
    step(cur, 4'h8, 1'b0);
    hold(2);

    // Reset while ch0 is two counts into a pending fall.
    cur[0] = 1'b0;
    step(cur, '0, 1'b0);
    hold(3);
    step(cur, '0, 1'b1);
    step(cur, '0, 1'b1);
    hold(8);

    for (int i = 0; i < 600; i++) begin
      logic [CH-1:0] clr;
      for (int ch = 0; ch < CH; ch++)
        if ($urandom_range(0, 5) == 0) cur[ch] = ~cur[ch];
      clr = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
      if ($urandom_range(0, 249) == 0) begin
        step(cur, clr, 1'b1);
        step(cur, clr, 1'b1);
      end else begin
        step(cur, clr, 1'b0);
      end
    end
    hold(6);
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    check("sb_drained", sb.size(), 0);

    // Three-stage chain with no filtering: q follows three edges after the sampling edge.
    @(negedge clk_i);
    rst2 = 1'b0;
    repeat (3) @(negedge clk_i);
    d2  = 4'h1;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk_i);
      #1;
      lat++;
      if (q2[0]) begin
        got = 1'b1;
        check("u2_rise", rise2, 4'h1);
      end
    end
    check("u2_latency", lat - 1, STG2 + FILT2 - 1);
    @(posedge clk_i);
    #1;
    check("u2_rise_single", rise2, 0);
    check("u2_evt", evt2, 4'h1);
    @(negedge clk_i);
    rst2 = 1'b1;
    #1;
    check("u2_async_q", q2, 0);
    check("u2_async_fall", fall2, 0);
    @(negedge clk_i);
    rst2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
